pipe_stage_buf: RTL
===================

// Module: pipe_stage_buf
// PURPOSE
// - Parametrised elastic buffer for one pipeline boundary (ID->EX, EX->MEM, MEM->WB).
// - Carries one packed stage word of DATA_W bits. Buffers DEPTH entries.
// - Uses a valid/ready handshake on both sides, plus a synchronous flush.
// - Replaces the bare per-stage flop. Lets a downstream stall or a branch flush act
//   without a combinational ready chain back through the pipe.
// PARAMETERS
// - DATA_W  512  width of the stage word, packed struct bits (>=1)
// - DEPTH   2    number of entries; power of two, 1..16
// - BYPASS  0    1: when empty, in_data is forwarded combinationally to out_data
// PORTS
// - clk        in   1          rising-edge clock, single domain
// - rst        in   1          synchronous, active-high reset
// - flush      in   1          synchronous, drops all entries
// - in_valid   in   1          upstream word valid
// - in_ready   out  1          buffer can accept
// - in_data    in   DATA_W     upstream stage word
// - out_valid  out  1          word available downstream
// - out_ready  in   1          downstream accepts
// - out_data   out  DATA_W     head stage word
// - count      out  CW         occupancy 0..DEPTH; CW = $clog2(DEPTH+1)
// BEHAVIOUR
// - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0 and count=0.
//   Afterwards out_valid=0, in_ready=1, out_data=0, count=0.
//   Storage array is not cleared.
// - push = in_valid & in_ready. pop = out_valid & out_ready (head from storage).
// - in_ready = (count != DEPTH). It is registered state only.
//   No combinational path from out_ready to in_ready.
// - Full and pop in the same cycle: no push that cycle (in_ready=0). Pop proceeds.
// - out_valid = (count != 0), or BYPASS & in_valid when count==0.
// - out_data = mem[rd_ptr] when count!=0.
//   It is in_data in the BYPASS-empty case, and 0 when out_valid=0.
// - Latency, BYPASS=0: word pushed at edge N appears at out after edge N, i.e. 1 cycle.
// - Latency, BYPASS=1: an empty buffer gives 0 cycles.
//   A bypassed word accepted downstream (out_ready=1) is not written.
//   If out_ready=0, it is written normally (push) and held.
// - Push and pop in the same cycle: both pointers advance and count is unchanged.
//   Legal at any count 1..DEPTH-1.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. At DEPTH=1 the pointers are
//   constant 0.
// - count: +1 on push only, -1 on pop only. It never exceeds DEPTH and never
//   underflows.
// - Flush (flush=1 at posedge): same effect as reset on pointers and count.
//   Any push or pop in that cycle is discarded.
//   For the rest of the flush cycle: out_valid=0 and in_ready=0.
//   Exception: with BYPASS=1, out_valid still forwards in_valid.
//   Both sides must treat that forwarded word as killed; flush is fanned out to them too.
// - Priority: rst > flush > push/pop.
// - Reset or flush mid-stream: all held words are lost.
//   The next push after deassertion lands at entry 0.
// - Stall: out_ready=0 holds out_data stable until the pop, with out_valid=1.
//   Upstream fills to DEPTH, then sees in_ready=0.
// - Words leave in strict FIFO order. No reordering and no duplication.
// TESTING
// - Reset: rst 1 for 2 cycles -> out_valid=0, in_ready=1, count=0, out_data=0.
// - Streaming, DEPTH=2, BYPASS=0, out_ready=1:
//   push 0xA1,0xA2,0xA3 back-to-back -> out 0xA1,0xA2,0xA3 one cycle later each.
//   count stays 1.
// - Backpressure: out_ready=0, push 0xB1,0xB2 -> count=2, in_ready=0.
//   Third word is held upstream.
//   out_ready=1 -> 0xB1 then 0xB2, then the third word, with no loss.
// - Wrap, DEPTH=4: 10 words 0..9, pushed and popped at random ready ->
//   order is 0..9 and count never exceeds 4.
// - Flush: count=2 and flush asserted with in_valid=1 ->
//   next cycle count=0, out_valid=0; the flushed-cycle word is not stored.
// - BYPASS=1, empty, in_valid=1 with 0xC5 and out_ready=1 ->
//   out_data=0xC5 same cycle and count stays 0.
//   With out_ready=0 -> count=1 next cycle, out_data=0xC5.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready buffer for one pipeline stage boundary
module pipe_stage_buf #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic byp_en;
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass_take;
    logic wr_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign byp_en = (BYPASS != 0);
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));

    // in_ready depends only on occupancy and flush, never on out_ready.
    assign in_ready    = ~full & ~flush;
    assign push        = in_valid & in_ready;
    assign pop         = ~empty & out_ready & ~flush;
    assign bypass_take = byp_en & empty & in_valid & out_ready;
    assign wr_en       = push & ~bypass_take;

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if (!flush && !empty) begin
            out_valid = 1'b1;
            out_data  = mem_q[rd_ptr_q];
        end else if (byp_en && in_valid) begin
            out_valid = 1'b1;
            out_data  = in_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign count = count_q;

endmodule
